vx_wb_commit: RTL and testbench
===============================

# VX_wb_commit

Writeback commit unit: the consumer (slave) end of the core writeback interface. Accepts writeback beats from the execute/commit arbiter through a 2-entry skid buffer and drives the GPR file write port. Emits a scoreboard release pulse on end-of-packet beats and keeps per-warp last-committed PC and a global commit counter for debug and perf. Sits between the writeback arbiter and the GPR file / scoreboard.

## Interface
- NUM_THREADS, 4, threads per warp
- NUM_WARPS, 4, warps per core; NW_BITS = max(1, $clog2(NUM_WARPS))
- NR_BITS, 6, register index width
- UUID_BITS, 44, instruction UUID width (debug trace only; not stored past the buffer)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wb_valid_in  in  1  writeback beat valid
- wb_uuid_in  in  UUID_BITS  instruction UUID
- wb_tmask_in  in  NUM_THREADS  active thread mask
- wb_wid_in  in  NW_BITS  warp id
- wb_PC_in  in  32  instruction PC
- wb_rd_in  in  NR_BITS  destination register
- wb_data_in  in  NUM_THREADS*32  per-thread result, thread t at [32t+31:32t]
- wb_eop_in  in  1  last beat of this instruction
- wb_ready_out  out  1  buffer can accept a beat
- gpr_wr_valid  out  1  GPR write request
- gpr_wr_ready  in  1  GPR write port free this cycle
- gpr_wr_mask  out  NUM_THREADS  per-thread write enable
- gpr_wr_wid  out  NW_BITS  warp id
- gpr_wr_rd  out  NR_BITS  register index
- gpr_wr_data  out  NUM_THREADS*32  write data
- sb_release_valid  out  1  one-cycle scoreboard release pulse
- sb_release_wid  out  NW_BITS  warp to release
- sb_release_rd  out  NR_BITS  register to release
- dbg_wid  in  NW_BITS  warp select for PC readback
- dbg_last_pc  out  32  last committed PC of warp dbg_wid (combinational read)
- commit_count  out  32  number of committed eop beats

## Operation
- Buffer: 2-entry FIFO (head/tail pointers, 2-bit count 0..2). Entry = {uuid, tmask, wid, PC, rd, data, eop}.
- wb_ready_out = (count != 2), derived from registered count only; no combinational path from gpr_wr_ready.
- Push = wb_valid_in && wb_ready_out. Payload ignored when not pushed.
- Head non-empty: gpr_wr_valid = (head.rd != 0); gpr_wr_mask = head.tmask; wid/rd/data from head.
- Pop = non-empty && (gpr_wr_ready || head.rd == 0). rd==0 beats (r0 hardwired) drain without a GPR write and without waiting on gpr_wr_ready.
- On pop with head.eop=1: register sb_release_valid=1, wid, rd (released also for rd==0); last_pc[head.wid] <= head.PC; commit_count += 1 (wraps 2^32-1 -> 0).
- On pop with eop=0: no release, no counter or last_pc update.
- Simultaneous push and pop: count unchanged; pointers both advance.
- When empty: gpr_wr_valid=0, gpr_wr_mask=0; wid/rd/data don't-care.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, wb_ready_out=1, gpr_wr_valid=0, gpr_wr_mask=0, sb_release_valid=0, release wid/rd=0, all last_pc=0, commit_count=0. Buffered entries are discarded; no release for them.
- Latency: beat accepted at edge N -> gpr_wr_valid during cycle N+1 (earliest); GPR write at edge N+1 if gpr_wr_ready. Release pulse valid during cycle N+2; commit_count/last_pc visible from cycle N+2.
- Throughput: one beat per cycle sustained when gpr_wr_ready=1.
- Stall: with gpr_wr_ready=0 and rd!=0 at head, two beats fill the buffer; wb_ready_out drops in the cycle after the second push, resumes the cycle after a pop.
- Head outputs stable while gpr_wr_valid=1 and gpr_wr_ready=0.

## Test plan
- Reset then idle -> wb_ready_out=1, gpr_wr_valid=0, commit_count=0, dbg_last_pc=0 for every warp.
- Single beat wid=2, rd=5, tmask=4'b1011, PC=0x8000_0010, eop=1, gpr_wr_ready=1 -> gpr_wr_valid in cycle 1 with mask 1011, release pulse (2,5) in cycle 2, commit_count=1, dbg_last_pc[2]=0x8000_0010.
- gpr_wr_ready=0, three back-to-back beats -> first two accepted, wb_ready_out=0 from cycle 2, third held; raise ready -> three writes in order, no loss or duplication.
- Beat rd=0, eop=1, gpr_wr_ready=0 -> gpr_wr_valid stays 0, entry drains next cycle, release pulse (wid,0), commit_count increments.
- Two-beat instruction (eop=0 then eop=1) -> two GPR writes, exactly one release and one commit_count increment.
- Preload commit_count via 2^32 commits (or forced value 0xFFFF_FFFF) then one eop -> wraps to 0; assert reset with 2 entries buffered -> empty, no release pulse after reset.

Source files
------------

// File: rtl/vx_wb_commit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : vx_wb_commit_if
// Description : Writeback beat bus from the writeback arbiter (master) to the
//               writeback commit unit (slave). Valid/ready handshake.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface vx_wb_commit_if #(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44
);
  logic                      valid;
  logic [UUID_BITS-1:0]      uuid;
  logic [NUM_THREADS-1:0]    tmask;
  logic [NW_BITS-1:0]        wid;
  logic [31:0]               PC;
  logic [NR_BITS-1:0]        rd;
  logic [NUM_THREADS*32-1:0] data;
  logic                      eop;
  logic                      ready;

  modport master (
    output valid, uuid, tmask, wid, PC, rd, data, eop,
    input  ready
  );

  modport slave (
    input  valid, uuid, tmask, wid, PC, rd, data, eop,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/vx_wb_commit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : vx_wb_commit
// Description : Writeback commit unit. Buffers writeback beats in a 2-entry
//               skid FIFO, drives the GPR write port, pulses a scoreboard
//               release on end-of-packet beats, and tracks per-warp last
//               committed PC plus a global commit counter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module vx_wb_commit #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_WARPS   = 4,
  parameter  int NR_BITS     = 6,
  parameter  int UUID_BITS   = 44,
  localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  vx_wb_commit_if.slave                  wb_if,
  output logic                           gpr_wr_valid,
  input  wire logic                      gpr_wr_ready,
  output logic [NUM_THREADS-1:0]         gpr_wr_mask,
  output logic [NW_BITS-1:0]             gpr_wr_wid,
  output logic [NR_BITS-1:0]             gpr_wr_rd,
  output logic [NUM_THREADS*32-1:0]      gpr_wr_data,
  output logic                           sb_release_valid,
  output logic [NW_BITS-1:0]             sb_release_wid,
  output logic [NR_BITS-1:0]             sb_release_rd,
  input  wire logic [NW_BITS-1:0]        dbg_wid,
  output logic [31:0]                    dbg_last_pc,
  output logic [31:0]                    commit_count
);

  // FIFO control
  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;

  // FIFO payload storage, indexed by head/tail pointer
  logic [UUID_BITS-1:0]      uuid_q  [2];
  logic [NUM_THREADS-1:0]    tmask_q [2];
  logic [NW_BITS-1:0]        wid_q   [2];
  logic [31:0]               pc_q    [2];
  logic [NR_BITS-1:0]        rd_q    [2];
  logic [NUM_THREADS*32-1:0] data_q  [2];
  logic                      eop_q   [2];

  // Commit tracking
  logic [31:0] commit_count_q, commit_count_d;
  logic [31:0] last_pc_q [NUM_WARPS];

  logic              sb_release_valid_q;
  logic [NW_BITS-1:0] sb_release_wid_q;
  logic [NR_BITS-1:0] sb_release_rd_q;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_rd_zero;
  logic w_commit;

  // UUID rides along for trace visibility only; nothing consumes it here.
  logic w_unused_uuid;
  assign w_unused_uuid = ^{uuid_q[0], uuid_q[1]};

  // Ready depends only on registered occupancy so the upstream never sees a
  // combinational path from the GPR port back-pressure.
  assign wb_if.ready = (count_q != 2'd2);

  assign w_empty   = (count_q == 2'd0);
  assign w_push    = wb_if.valid && wb_if.ready;
  // r0 is hardwired: such beats retire without touching the GPR port.
  assign w_rd_zero = (rd_q[head_q] == '0);
  assign w_pop     = !w_empty && (gpr_wr_ready || w_rd_zero);
  assign w_commit  = w_pop && eop_q[head_q];

  assign gpr_wr_valid = !w_empty && !w_rd_zero;
  assign gpr_wr_mask  = w_empty ? '0 : tmask_q[head_q];
  assign gpr_wr_wid   = wid_q[head_q];
  assign gpr_wr_rd    = rd_q[head_q];
  assign gpr_wr_data  = data_q[head_q];

  assign sb_release_valid = sb_release_valid_q;
  assign sb_release_wid   = sb_release_wid_q;
  assign sb_release_rd    = sb_release_rd_q;

  assign commit_count = commit_count_q;
  assign dbg_last_pc  = last_pc_q[dbg_wid];

  // Next-state for pointers, occupancy and the commit counter
  always_comb begin
    count_d        = count_q;
    head_d         = head_q;
    tail_d         = tail_q;
    commit_count_d = commit_count_q;
    if (w_push) tail_d = ~tail_q;
    if (w_pop)  head_d = ~head_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (w_commit) commit_count_d = commit_count_q + 32'd1;
  end

  // Control state register; reset discards any buffered entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      commit_count_q <= 32'd0;
    end else begin
      count_q        <= count_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      commit_count_q <= commit_count_d;
    end
  end

  // Payload capture at the tail slot; contents are qualified by count
  always_ff @(posedge clk) begin
    if (w_push) begin
      uuid_q[tail_q]  <= wb_if.uuid;
      tmask_q[tail_q] <= wb_if.tmask;
      wid_q[tail_q]   <= wb_if.wid;
      pc_q[tail_q]    <= wb_if.PC;
      rd_q[tail_q]    <= wb_if.rd;
      data_q[tail_q]  <= wb_if.data;
      eop_q[tail_q]   <= wb_if.eop;
    end
  end

  // One-cycle scoreboard release registered from an end-of-packet pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_release_valid_q <= 1'b0;
      sb_release_wid_q   <= '0;
      sb_release_rd_q    <= '0;
    end else begin
      sb_release_valid_q <= w_commit;
      if (w_commit) begin
        sb_release_wid_q <= wid_q[head_q];
        sb_release_rd_q  <= rd_q[head_q];
      end
    end
  end

  // Per-warp last committed PC, updated on end-of-packet pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        last_pc_q[w] <= 32'd0;
      end
    end else if (w_commit) begin
      last_pc_q[wid_q[head_q]] <= pc_q[head_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_wb_commit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_vx_wb_commit
// Description : Directed self-checking bench for vx_wb_commit.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_vx_wb_commit;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NW_BITS     = 2;
  localparam int NR_BITS     = 6;
  localparam int UUID_BITS   = 44;

  logic                      clk;
  logic                      reset;
  logic                      gpr_wr_valid;
  logic                      gpr_wr_ready;
  logic [NUM_THREADS-1:0]    gpr_wr_mask;
  logic [NW_BITS-1:0]        gpr_wr_wid;
  logic [NR_BITS-1:0]        gpr_wr_rd;
  logic [NUM_THREADS*32-1:0] gpr_wr_data;
  logic                      sb_release_valid;
  logic [NW_BITS-1:0]        sb_release_wid;
  logic [NR_BITS-1:0]        sb_release_rd;
  logic [NW_BITS-1:0]        dbg_wid;
  logic [31:0]               dbg_last_pc;
  logic [31:0]               commit_count;

  int checks = 0;
  int errors = 0;

  vx_wb_commit_if #(
    .NUM_THREADS(NUM_THREADS), .NW_BITS(NW_BITS),
    .NR_BITS(NR_BITS), .UUID_BITS(UUID_BITS)
  ) wb_if ();

  vx_wb_commit #(
    .NUM_THREADS(NUM_THREADS), .NUM_WARPS(NUM_WARPS),
    .NR_BITS(NR_BITS), .UUID_BITS(UUID_BITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_if            (wb_if),
    .gpr_wr_valid     (gpr_wr_valid),
    .gpr_wr_ready     (gpr_wr_ready),
    .gpr_wr_mask      (gpr_wr_mask),
    .gpr_wr_wid       (gpr_wr_wid),
    .gpr_wr_rd        (gpr_wr_rd),
    .gpr_wr_data      (gpr_wr_data),
    .sb_release_valid (sb_release_valid),
    .sb_release_wid   (sb_release_wid),
    .sb_release_rd    (sb_release_rd),
    .dbg_wid          (dbg_wid),
    .dbg_last_pc      (dbg_last_pc),
    .commit_count     (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input logic [1:0] w, input logic [31:0] exp);
    dbg_wid = w;
    #1;
    chk($sformatf("last_pc[%0d]", w), {96'd0, dbg_last_pc}, {96'd0, exp});
  endtask

  task automatic beat(input logic [1:0] wid, input logic [5:0] rd, input logic [3:0] tm,
                      input logic [31:0] pc, input logic [127:0] d, input logic eop);
    wb_if.valid = 1'b1;
    wb_if.uuid  = {12'd0, pc};
    wb_if.wid   = wid;
    wb_if.rd    = rd;
    wb_if.tmask = tm;
    wb_if.PC    = pc;
    wb_if.data  = d;
    wb_if.eop   = eop;
  endtask

  task automatic idle();
    wb_if.valid = 1'b0;
  endtask

  localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] DA = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] DB = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] DC = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;

  initial begin
    reset        = 1'b1;
    gpr_wr_ready = 1'b1;
    dbg_wid      = '0;
    wb_if.valid  = 1'b0;
    wb_if.uuid   = '0;
    wb_if.tmask  = '0;
    wb_if.wid    = '0;
    wb_if.PC     = '0;
    wb_if.rd     = '0;
    wb_if.data   = '0;
    wb_if.eop    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_ready",  {127'd0, wb_if.ready}, 128'd1);
    chk("rst_gvalid", {127'd0, gpr_wr_valid}, 128'd0);
    chk("rst_gmask",  {124'd0, gpr_wr_mask}, 128'd0);
    chk("rst_rel",    {127'd0, sb_release_valid}, 128'd0);
    chk("rst_count",  {96'd0, commit_count}, 128'd0);
    for (int w = 0; w < NUM_WARPS; w++) chk_pc(w[1:0], 32'd0);

    // Single eop beat, GPR port free
    beat(2'd2, 6'd5, 4'b1011, 32'h8000_0010, D1, 1'b1);
    tick();
    idle();
    chk("s_gvalid", {127'd0, gpr_wr_valid}, 128'd1);
    chk("s_gmask",  {124'd0, gpr_wr_mask}, 128'hB);
    chk("s_gwid",   {126'd0, gpr_wr_wid}, 128'd2);
    chk("s_grd",    {122'd0, gpr_wr_rd}, 128'd5);
    chk("s_gdata",  gpr_wr_data, D1);
    chk("s_rel0",   {127'd0, sb_release_valid}, 128'd0);
    tick();
    chk("s_rel",    {127'd0, sb_release_valid}, 128'd1);
    chk("s_relwid", {126'd0, sb_release_wid}, 128'd2);
    chk("s_relrd",  {122'd0, sb_release_rd}, 128'd5);
    chk("s_count",  {96'd0, commit_count}, 128'd1);
    chk("s_gidle",  {127'd0, gpr_wr_valid}, 128'd0);
    chk_pc(2'd2, 32'h8000_0010);
    tick();
    chk("s_relend", {127'd0, sb_release_valid}, 128'd0);

    // Stall: three back-to-back beats with GPR port busy
    gpr_wr_ready = 1'b0;
    beat(2'd0, 6'd1, 4'b1111, 32'h0000_1000, DA, 1'b1);
    tick();
    chk("st_ready1", {127'd0, wb_if.ready}, 128'd1);
    beat(2'd0, 6'd2, 4'b0011, 32'h0000_1004, DB, 1'b1);
    tick();
    chk("st_ready2", {127'd0, wb_if.ready}, 128'd0);
    beat(2'd0, 6'd3, 4'b0101, 32'h0000_1008, DC, 1'b1);
    tick();
    chk("st_hold_rdy", {127'd0, wb_if.ready}, 128'd0);
    chk("st_hold_v",   {127'd0, gpr_wr_valid}, 128'd1);
    chk("st_hold_rd",  {122'd0, gpr_wr_rd}, 128'd1);
    tick();
    chk("st_hold_rd2", {122'd0, gpr_wr_rd}, 128'd1);
    chk("st_hold_d",   gpr_wr_data, DA);
    gpr_wr_ready = 1'b1;
    tick();
    chk("st_w2_rd",   {122'd0, gpr_wr_rd}, 128'd2);
    chk("st_w2_d",    gpr_wr_data, DB);
    chk("st_w2_mask", {124'd0, gpr_wr_mask}, 128'h3);
    chk("st_ready3",  {127'd0, wb_if.ready}, 128'd1);
    tick();
    idle();
    chk("st_w3_rd",   {122'd0, gpr_wr_rd}, 128'd3);
    chk("st_w3_d",    gpr_wr_data, DC);
    chk("st_w3_mask", {124'd0, gpr_wr_mask}, 128'h5);
    tick();
    chk("st_empty",   {127'd0, gpr_wr_valid}, 128'd0);
    chk("st_relrd",   {122'd0, sb_release_rd}, 128'd3);
    chk("st_count",   {96'd0, commit_count}, 128'd4);
    chk_pc(2'd0, 32'h0000_1008);

    // rd==0 drains without a GPR write even when the port is busy
    gpr_wr_ready = 1'b0;
    beat(2'd1, 6'd0, 4'b1111, 32'h0000_0100, D1, 1'b1);
    tick();
    idle();
    chk("r0_gvalid", {127'd0, gpr_wr_valid}, 128'd0);
    tick();
    chk("r0_rel",    {127'd0, sb_release_valid}, 128'd1);
    chk("r0_relwid", {126'd0, sb_release_wid}, 128'd1);
    chk("r0_relrd",  {122'd0, sb_release_rd}, 128'd0);
    chk("r0_count",  {96'd0, commit_count}, 128'd5);
    chk("r0_mask",   {124'd0, gpr_wr_mask}, 128'd0);
    chk_pc(2'd1, 32'h0000_0100);

    // Two-beat instruction: one release and one count increment
    gpr_wr_ready = 1'b1;
    beat(2'd3, 6'd7, 4'b1100, 32'h0000_0200, DA, 1'b0);
    tick();
    chk("mb_w1_d", gpr_wr_data, DA);
    beat(2'd3, 6'd7, 4'b1100, 32'h0000_0204, DB, 1'b1);
    tick();
    idle();
    chk("mb_w2_v",   {127'd0, gpr_wr_valid}, 128'd1);
    chk("mb_w2_d",   gpr_wr_data, DB);
    chk("mb_norel",  {127'd0, sb_release_valid}, 128'd0);
    chk("mb_count1", {96'd0, commit_count}, 128'd5);
    tick();
    chk("mb_rel",    {127'd0, sb_release_valid}, 128'd1);
    chk("mb_relwid", {126'd0, sb_release_wid}, 128'd3);
    chk("mb_relrd",  {122'd0, sb_release_rd}, 128'd7);
    chk("mb_count2", {96'd0, commit_count}, 128'd6);
    chk_pc(2'd3, 32'h0000_0204);
    tick();
    chk("mb_relend", {127'd0, sb_release_valid}, 128'd0);
    chk("mb_count3", {96'd0, commit_count}, 128'd6);

    // Counter wrap from 0xFFFF_FFFF
    force dut.commit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count_q;
    #1;
    chk("wr_pre", {96'd0, commit_count}, {96'd0, 32'hFFFF_FFFF});
    beat(2'd0, 6'd4, 4'b0001, 32'h0000_0300, DC, 1'b1);
    tick();
    idle();
    tick();
    chk("wr_wrap", {96'd0, commit_count}, 128'd0);

    // Reset with two entries buffered discards them
    gpr_wr_ready = 1'b0;
    beat(2'd2, 6'd9, 4'b1111, 32'h0000_0400, DA, 1'b1);
    tick();
    beat(2'd2, 6'd10, 4'b1111, 32'h0000_0404, DB, 1'b1);
    tick();
    idle();
    chk("rb_full", {127'd0, wb_if.ready}, 128'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_ready",  {127'd0, wb_if.ready}, 128'd1);
    chk("rb_gvalid", {127'd0, gpr_wr_valid}, 128'd0);
    chk("rb_count",  {96'd0, commit_count}, 128'd0);
    tick();
    reset = 1'b0;
    gpr_wr_ready = 1'b1;
    tick();
    chk("rb_rel1",   {127'd0, sb_release_valid}, 128'd0);
    chk("rb_gv1",    {127'd0, gpr_wr_valid}, 128'd0);
    tick();
    chk("rb_rel2",   {127'd0, sb_release_valid}, 128'd0);
    chk("rb_count2", {96'd0, commit_count}, 128'd0);
    chk_pc(2'd2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
